layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/layer_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_layer_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// layer_scheduler
//   Runs a job of num_layers layers. Each layer goes through three phases,
//   load -> compute -> save, and each phase is a request/completion handshake
//   with an external engine. A job with zero layers finishes at once with a
//   job_done pulse.
//
// Ports
//   clk                           single clock, rising edge
//   rst                           asynchronous reset, active low
//   start, num_layers             job request; num_layers is sampled when start is accepted
//   abort                         ends a running job at once, without job_done
//   load_req/comp_req/save_req    phase requests, high for the whole phase
//   load_done/comp_done/save_done one-cycle phase completion pulses
//   state                         00 IDLE, 01 MEM_LOAD, 10 MEM_SAVE, 11 COMPUTATION
//   layer_idx                     current layer, 0-based; holds its last value in IDLE
//   busy                          high whenever state is not IDLE
//   job_done                      one-cycle pulse on normal completion
//   error                         sticky watchdog timeout flag, cleared by the next start
//
// Optional feature
//   LAYER_SCHED_WATCHDOG_EN  when defined, each phase is limited by a WDOG_W-bit
//                            watchdog; without it phases wait forever and error
//                            is tied low.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no job; waits for start
// LOAD  | load_req high, waits for load_done
// COMP  | comp_req high, waits for comp_done
// SAVE  | save_req high, waits for save_done; then next layer or done

module layer_scheduler #(
  parameter int LAYER_W = 8,
  parameter int WDOG_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               abort,
  output logic               load_req,
  output logic               comp_req,
  output logic               save_req,
  input  logic               load_done,
  input  logic               comp_done,
  input  logic               save_done,
  output logic [1:0]         state,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               job_done,
  output logic               error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_SAVE = 2'b10,
    S_COMP = 2'b11
  } state_t;

  state_t             cur;
  logic [LAYER_W-1:0] count;
  logic               last_layer;

  // A watchdog narrower than 2 bits cannot express a meaningful timeout.
  if (WDOG_W < 2) begin : g_wdog_w_check
    $error("layer_scheduler: WDOG_W must be at least 2");
  end

  assign state      = cur;
  assign last_layer = (layer_idx == (count - LAYER_W'(1)));

`ifdef LAYER_SCHED_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;
  logic              timeout;

  // The counter starts at 0 on phase entry; leaving when it holds all-ones
  // minus one means it would reach all-ones on the same edge the phase is
  // abandoned, giving exactly 2**WDOG_W - 1 cycles in the phase.
  assign timeout = (wdog == {{(WDOG_W-1){1'b1}}, 1'b0});
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_IDLE;
      count     <= '0;
      layer_idx <= '0;
      load_req  <= 1'b0;
      comp_req  <= 1'b0;
      save_req  <= 1'b0;
      busy      <= 1'b0;
      job_done  <= 1'b0;
      error     <= 1'b0;
`ifdef LAYER_SCHED_WATCHDOG_EN
      wdog      <= '0;
`endif
    end else begin
      job_done <= 1'b0;
`ifdef LAYER_SCHED_WATCHDOG_EN
      wdog     <= (cur == S_IDLE) ? '0 : wdog + WDOG_W'(1);
`endif
      case (cur)
        S_IDLE: begin
          // abort outranks start; abort alone in IDLE does nothing
          if (start && !abort) begin
            error <= 1'b0;
            if (num_layers != '0) begin
              count     <= num_layers;
              layer_idx <= '0;
              cur       <= S_LOAD;
              load_req  <= 1'b1;
              busy      <= 1'b1;
`ifdef LAYER_SCHED_WATCHDOG_EN
              wdog      <= '0;
`endif
            end else begin
              job_done <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (abort) begin
            cur      <= S_IDLE;
            load_req <= 1'b0;
            busy     <= 1'b0;
          end else if (load_done) begin
            cur      <= S_COMP;
            load_req <= 1'b0;
            comp_req <= 1'b1;
`ifdef LAYER_SCHED_WATCHDOG_EN
            wdog     <= '0;
          end else if (timeout) begin
            cur      <= S_IDLE;
            load_req <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
`endif
          end
        end

        S_COMP: begin
          if (abort) begin
            cur      <= S_IDLE;
            comp_req <= 1'b0;
            busy     <= 1'b0;
          end else if (comp_done) begin
            cur      <= S_SAVE;
            comp_req <= 1'b0;
            save_req <= 1'b1;
`ifdef LAYER_SCHED_WATCHDOG_EN
            wdog     <= '0;
          end else if (timeout) begin
            cur      <= S_IDLE;
            comp_req <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
`endif
          end
        end

        S_SAVE: begin
          if (abort) begin
            cur      <= S_IDLE;
            save_req <= 1'b0;
            busy     <= 1'b0;
          end else if (save_done) begin
            save_req <= 1'b0;
            if (last_layer) begin
              cur      <= S_IDLE;
              busy     <= 1'b0;
              job_done <= 1'b1;
            end else begin
              cur       <= S_LOAD;
              layer_idx <= layer_idx + LAYER_W'(1);
              load_req  <= 1'b1;
`ifdef LAYER_SCHED_WATCHDOG_EN
              wdog      <= '0;
`endif
            end
`ifdef LAYER_SCHED_WATCHDOG_EN
          end else if (timeout) begin
            cur      <= S_IDLE;
            save_req <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
`endif
          end
        end

        default: begin
          cur      <= S_IDLE;
          load_req <= 1'b0;
          comp_req <= 1'b0;
          save_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler
//   Directed bench for layer_scheduler: reset values, a nominal 3-layer job,
//   zero-layer job, stray done pulses, abort against a simultaneous done and
//   a simultaneous start, watchdog timeout (when LAYER_SCHED_WATCHDOG_EN is
//   defined) and reset in the middle of a job.

module tb_layer_scheduler;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_SAVE = 2'b10;
  localparam logic [1:0] ST_COMP = 2'b11;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_layers;
  logic       abort;
  logic       load_req, comp_req, save_req;
  logic       load_done, comp_done, save_done;
  logic [1:0] state;
  logic [7:0] layer_idx;
  logic       busy;
  logic       job_done;
  logic       error;

  int checks   = 0;
  int failures = 0;

  layer_scheduler #(.LAYER_W(8), .WDOG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_layers (num_layers),
    .abort      (abort),
    .load_req   (load_req),
    .comp_req   (comp_req),
    .save_req   (save_req),
    .load_done  (load_done),
    .comp_done  (comp_done),
    .save_done  (save_done),
    .state      (state),
    .layer_idx  (layer_idx),
    .busy       (busy),
    .job_done   (job_done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full output snapshot against expected state, layer, job_done and error
  task automatic check_outs(input string tag, input logic [1:0] st, input logic [7:0] idx,
                            input logic jd, input logic er);
    check({tag, ".state"},    32'(state),     32'(st));
    check({tag, ".load_req"}, 32'(load_req),  32'(st == ST_LOAD));
    check({tag, ".comp_req"}, 32'(comp_req),  32'(st == ST_COMP));
    check({tag, ".save_req"}, 32'(save_req),  32'(st == ST_SAVE));
    check({tag, ".busy"},     32'(busy),      32'(st != ST_IDLE));
    check({tag, ".layer"},    32'(layer_idx), 32'(idx));
    check({tag, ".job_done"}, 32'(job_done),  32'(jd));
    check({tag, ".error"},    32'(error),     32'(er));
  endtask

  // Called on the first visible cycle of a phase; done arrives 4 cycles after req.
  task automatic phase_step(input string tag, input logic [1:0] st, input logic [7:0] idx);
    check_outs(tag, st, idx, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      check({tag, ".hold"}, 32'(state), 32'(st));
    end
    case (st)
      ST_LOAD: load_done = 1'b1;
      ST_COMP: comp_done = 1'b1;
      default: save_done = 1'b1;
    endcase
    tick();
    load_done = 1'b0;
    comp_done = 1'b0;
    save_done = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] n);
    num_layers = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_layers = '0;
    abort      = 1'b0;
    load_done  = 1'b0;
    comp_done  = 1'b0;
    save_done  = 1'b0;

    // reset
    #1 rst = 1'b0;
    #1;
    check_outs("reset", ST_IDLE, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_outs("post_reset", ST_IDLE, 8'd0, 1'b0, 1'b0);

    // nominal 3-layer job; a start during layer 0 compute must be ignored
    do_start(8'd3);
    for (int l = 0; l < 3; l++) begin
      phase_step("nom_load", ST_LOAD, 8'(l));
      if (l == 0) begin
        num_layers = 8'd7;
        start      = 1'b1;
        check_outs("busy_start_pre", ST_COMP, 8'd0, 1'b0, 1'b0);
        tick();
        start      = 1'b0;
        check_outs("busy_start_post", ST_COMP, 8'd0, 1'b0, 1'b0);
        repeat (2) tick();
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
      end else begin
        phase_step("nom_comp", ST_COMP, 8'(l));
      end
      phase_step("nom_save", ST_SAVE, 8'(l));
    end
    check_outs("nom_end", ST_IDLE, 8'd2, 1'b1, 1'b0);
    tick();
    check_outs("nom_after", ST_IDLE, 8'd2, 1'b0, 1'b0);

    // zero-layer job
    do_start(8'd0);
    check_outs("zero", ST_IDLE, 8'd2, 1'b1, 1'b0);
    tick();
    check_outs("zero_after", ST_IDLE, 8'd2, 1'b0, 1'b0);

    // stray done pulses: comp_done in MEM_LOAD, save_done in IDLE
    do_start(8'd1);
    check_outs("stray_entry", ST_LOAD, 8'd0, 1'b0, 1'b0);
    comp_done = 1'b1;
    save_done = 1'b1;
    tick();
    comp_done = 1'b0;
    save_done = 1'b0;
    phase_step("stray_load", ST_LOAD, 8'd0);
    phase_step("stray_comp", ST_COMP, 8'd0);
    phase_step("stray_save", ST_SAVE, 8'd0);
    check_outs("stray_done", ST_IDLE, 8'd0, 1'b1, 1'b0);
    save_done = 1'b1;
    load_done = 1'b1;
    tick();
    save_done = 1'b0;
    load_done = 1'b0;
    check_outs("stray_idle", ST_IDLE, 8'd0, 1'b0, 1'b0);

    // abort together with comp_done in layer 1
    do_start(8'd3);
    phase_step("ab_load0", ST_LOAD, 8'd0);
    phase_step("ab_comp0", ST_COMP, 8'd0);
    phase_step("ab_save0", ST_SAVE, 8'd0);
    phase_step("ab_load1", ST_LOAD, 8'd1);
    check_outs("ab_comp1", ST_COMP, 8'd1, 1'b0, 1'b0);
    abort     = 1'b1;
    comp_done = 1'b1;
    tick();
    abort     = 1'b0;
    comp_done = 1'b0;
    check_outs("abort", ST_IDLE, 8'd1, 1'b0, 1'b0);
    tick();
    check_outs("abort_after", ST_IDLE, 8'd1, 1'b0, 1'b0);

    // abort outranks a simultaneous start in IDLE
    abort = 1'b1;
    do_start(8'd2);
    abort = 1'b0;
    check_outs("abort_start", ST_IDLE, 8'd1, 1'b0, 1'b0);

    // new single-layer job after abort
    do_start(8'd1);
    phase_step("re_load", ST_LOAD, 8'd0);
    phase_step("re_comp", ST_COMP, 8'd0);
    phase_step("re_save", ST_SAVE, 8'd0);
    check_outs("re_done", ST_IDLE, 8'd0, 1'b1, 1'b0);
    tick();

`ifdef LAYER_SCHED_WATCHDOG_EN
    // withheld load_done: 15 cycles in MEM_LOAD, then IDLE with error
    do_start(8'd2);
    check_outs("wd_entry", ST_LOAD, 8'd0, 1'b0, 1'b0);
    repeat (14) tick();
    check_outs("wd_cycle15", ST_LOAD, 8'd0, 1'b0, 1'b0);
    tick();
    check_outs("wd_timeout", ST_IDLE, 8'd0, 1'b0, 1'b1);
    repeat (3) tick();
    check_outs("wd_sticky", ST_IDLE, 8'd0, 1'b0, 1'b1);
    do_start(8'd1);
    check_outs("wd_clear", ST_LOAD, 8'd0, 1'b0, 1'b0);
    phase_step("wd_load", ST_LOAD, 8'd0);
    phase_step("wd_comp", ST_COMP, 8'd0);
    phase_step("wd_save", ST_SAVE, 8'd0);
    check_outs("wd_done", ST_IDLE, 8'd0, 1'b1, 1'b0);
    tick();
`else
    // without the watchdog a phase waits as long as it takes
    do_start(8'd1);
    repeat (40) tick();
    check_outs("nowd_wait", ST_LOAD, 8'd0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outs("nowd_abort", ST_IDLE, 8'd0, 1'b0, 1'b0);
`endif

    // reset during COMPUTATION of layer 2
    do_start(8'd3);
    phase_step("rs_load0", ST_LOAD, 8'd0);
    phase_step("rs_comp0", ST_COMP, 8'd0);
    phase_step("rs_save0", ST_SAVE, 8'd0);
    phase_step("rs_load1", ST_LOAD, 8'd1);
    phase_step("rs_comp1", ST_COMP, 8'd1);
    phase_step("rs_save1", ST_SAVE, 8'd1);
    phase_step("rs_load2", ST_LOAD, 8'd2);
    check_outs("rs_comp2", ST_COMP, 8'd2, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    check_outs("rs_async", ST_IDLE, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
    save_done = 1'b1;
    tick();
    save_done = 1'b0;
    repeat (3) tick();
    check_outs("rs_release", ST_IDLE, 8'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
